// File: rtl/clk_ctrl_pkg.sv
// Shared mode encoding and entry limits for the clock input/control stage.
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'b00,
    MODE_SET_MIN  = 2'b01,
    MODE_SET_HOUR = 2'b10,
    MODE_RUN      = 2'b11
  } mode_t;

  localparam int MAX_MIN  = 59;
  localparam int MAX_HOUR = 23;
  localparam int BCD_MAX  = 9;

  function automatic mode_t next_mode(input mode_t cur);
    case (cur)
      MODE_OFF:      next_mode = MODE_SET_MIN;
      MODE_SET_MIN:  next_mode = MODE_SET_HOUR;
      MODE_SET_HOUR: next_mode = MODE_RUN;
      default:       next_mode = MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises an active-low push button, debounces it with a stability counter
// and emits a one-cycle pulse on each accepted press.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync_0;
  logic          sync_1;
  logic          level_n;
  logic          armed;
  logic [CW-1:0] cnt;

  // The synchroniser resets to "pressed" and armed waits for a released sample
  // at a released level, so a key held through reset never yields a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_0  <= 1'b0;
      sync_1  <= 1'b0;
      level_n <= 1'b1;
      armed   <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_0 <= key_n;
      sync_1 <= sync_0;
      press  <= 1'b0;
      if (sync_1 && level_n) armed <= 1'b1;
      if (sync_1 == level_n) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level_n <= sync_1;
        cnt     <= '0;
        press   <= armed && !sync_1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Mode sequencing, BCD entry validation with load strobes, and the 1 Hz tick
// feeding the HH:MM:SS clock core.
module time_set_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode_n,
  input  logic       key_load_n,
  input  logic [3:0] sw_data_0,
  input  logic [3:0] sw_data_1,
  output logic [1:0] mode,
  output logic       load_min,
  output logic       load_hour,
  output logic [5:0] load_val,
  output logic       tick_1hz,
  output logic       entry_err
);

  localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_HZ - 1);

  logic          mode_press;
  logic          load_press;
  mode_t         mode_q;
  logic [6:0]    val7;
  logic          digits_ok;
  logic [TW-1:0] tick_cnt;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode_key (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_mode_n),
    .press (mode_press)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_load_key (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_load_n),
    .press (load_press)
  );

  // Both digits <= 9 keep the 7-bit sum at most 99, so no overflow on valid entries.
  always_comb begin
    val7      = 7'(sw_data_1) * 7'd10 + 7'(sw_data_0);
    digits_ok = (sw_data_1 <= 4'(BCD_MAX)) && (sw_data_0 <= 4'(BCD_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_OFF;
      load_min  <= 1'b0;
      load_hour <= 1'b0;
      load_val  <= '0;
      entry_err <= 1'b0;
    end else begin
      load_min  <= 1'b0;
      load_hour <= 1'b0;
      load_val  <= '0;
      if (mode_press) begin
        mode_q    <= next_mode(mode_q);
        entry_err <= 1'b0;
      end else if (load_press) begin
        case (mode_q)
          MODE_SET_MIN: begin
            if (digits_ok && (val7 <= 7'(MAX_MIN))) begin
              load_min  <= 1'b1;
              load_val  <= val7[5:0];
              entry_err <= 1'b0;
            end else begin
              entry_err <= 1'b1;
            end
          end
          MODE_SET_HOUR: begin
            if (digits_ok && (val7 <= 7'(MAX_HOUR))) begin
              load_hour <= 1'b1;
              load_val  <= val7[5:0];
              entry_err <= 1'b0;
            end else begin
              entry_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // A mode press in RUN suppresses a coincident wrap so no tick lands outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      tick_1hz <= 1'b0;
    end else if (mode_q == MODE_RUN && !mode_press) begin
      if (tick_cnt == TICK_LAST) begin
        tick_cnt <= '0;
        tick_1hz <= 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
        tick_1hz <= 1'b0;
      end
    end else begin
      tick_cnt <= '0;
      tick_1hz <= 1'b0;
    end
  end

  assign mode = mode_q;

endmodule
